// File: rtl/tone_meter.sv
// tone_meter: measures rise-to-rise period and high time of a square wave in CLK cycles
// and flags loss of tone. Optional period matcher enabled by TONE_METER_MATCH_EN.
module tone_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             tone_in,
`ifdef TONE_METER_MATCH_EN
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] tolerance,
  output logic             locked,
`endif
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             no_tone
);

  localparam logic [WIDTH-1:0] TimeoutVal = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] Ones       = '1;
  localparam logic [WIDTH-1:0] One        = WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic             measure;
  logic             expire;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             no_tone_q, no_tone_d;

  // s1/s2 synchronise the pin; s3 delays s2 for edge detection.
  always_ff @(posedge CLK) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tone_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign measure = (state_q == StArmed) & rise;
  // A rise on the timeout cycle wins, so expiry requires no rise.
  assign expire  = (state_q == StArmed) & ~rise & (cnt_q == TimeoutVal);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    no_tone_d = no_tone_q;

    if (rise) begin
      cnt_d  = One;
      hcnt_d = One;
    end else begin
      if (cnt_q != Ones) cnt_d = cnt_q + One;
      if (s2_q && (hcnt_q != Ones)) hcnt_d = hcnt_q + One;
    end

    case (state_q)
      StIdle: begin
        if (rise) state_d = StArmed;
      end
      StArmed: begin
        if (measure) begin
          period_d  = cnt_q;
          high_d    = hcnt_q;
          valid_d   = 1'b1;
          no_tone_d = 1'b0;
        end else if (expire) begin
          state_d   = StIdle;
          no_tone_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      no_tone_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      no_tone_q <= no_tone_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign no_tone      = no_tone_q;

`ifdef TONE_METER_MATCH_EN
  logic [1:0]       hit_q, hit_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] diff;
  logic             match;

  always_comb begin
    diff     = (cnt_q >= expected) ? (cnt_q - expected) : (expected - cnt_q);
    match    = (diff <= tolerance);
    hit_d    = hit_q;
    locked_d = locked_q;
    if (measure) begin
      if (match) begin
        hit_d    = (hit_q == 2'd3) ? 2'd3 : hit_q + 2'd1;
        locked_d = (hit_q >= 2'd2);
      end else begin
        hit_d    = 2'd0;
        locked_d = 1'b0;
      end
    end else if (expire) begin
      hit_d    = 2'd0;
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      hit_q    <= 2'd0;
      locked_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`endif

endmodule

// File: tb/tb_tone_meter.sv
// Randomised self-checking bench for tone_meter; the model works on input rise times
// and high-cycle counts, with outputs expected two cycles after the driving input.
module tb_tone_meter;

  localparam int unsigned W = 32;
  localparam int unsigned T = 200;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         tone_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         period_valid;
  logic         no_tone;
`ifdef TONE_METER_MATCH_EN
  logic [W-1:0] expected;
  logic [W-1:0] tolerance;
  logic         locked;
`endif

  int unsigned m_expv = 80;
  int unsigned m_tol  = 2;

  tone_meter #(
    .WIDTH  (W),
    .TIMEOUT(T)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .tone_in     (tone_in),
`ifdef TONE_METER_MATCH_EN
    .expected    (expected),
    .tolerance   (tolerance),
    .locked      (locked),
`endif
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .no_tone     (no_tone)
  );

`ifdef TONE_METER_MATCH_EN
  assign expected  = m_expv;
  assign tolerance = m_tol;
`endif

  always #5 CLK = ~CLK;

  typedef struct {
    bit          pv;
    int unsigned per;
    int unsigned hi;
    bit          nt;
    bit          lk;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t pipe[2];

  // Reference model state
  bit          m_prev, m_armed, m_nt, m_lk;
  int unsigned m_since, m_hacc, m_per, m_hi, m_hits;

  // Observation bookkeeping for scenario checks
  int n_pv = 0;
  int last_pv_cyc = -1;
  int nt_rise_cyc = -1;
  bit nt_prev = 1'b1;

  task automatic model_reset();
    m_prev = 0; m_armed = 0; m_since = 0; m_hacc = 0;
    m_per = 0; m_hi = 0; m_nt = 1; m_hits = 0; m_lk = 0;
  endtask

  // Drive one cycle of tone_in, advance the model and compare outputs.
  task automatic step(input bit v);
    exp_t now, out;
    bit r;
    int unsigned d;
    tone_in = v;
    now.pv = 0;
    if (reset) begin
      model_reset();
    end else begin
      r = v && !m_prev;
      m_prev = v;
      m_since++;
      if (r) begin
        if (m_armed) begin
          m_per = m_since;
          m_hi  = m_hacc;
          m_nt  = 0;
          now.pv = 1;
          d = (m_per > m_expv) ? m_per - m_expv : m_expv - m_per;
          if (d <= m_tol) begin
            m_hits = (m_hits < 3) ? m_hits + 1 : 3;
            m_lk   = (m_hits == 3);
          end else begin
            m_hits = 0;
            m_lk   = 0;
          end
        end
        m_armed = 1;
        m_since = 0;
        m_hacc  = 0;
      end else if (m_armed && m_since == T) begin
        m_armed = 0;
        m_nt    = 1;
        m_hits  = 0;
        m_lk    = 0;
      end
      m_hacc += v;
    end
    now.per = m_per; now.hi = m_hi; now.nt = m_nt; now.lk = m_lk;
    if (reset) begin
      pipe[0] = now; pipe[1] = now; out = now;
    end else begin
      out = pipe[1]; pipe[1] = pipe[0]; pipe[0] = now;
    end

    @(posedge CLK);
    #1;
    cyc++;

    if (period_valid === 1'b1 || out.pv) begin
      checks++;
      if (period_valid !== out.pv) begin
        errors++;
        $display("FAIL period_valid @%0d: got %b expected %b", cyc, period_valid, out.pv);
      end
    end
    if (out.pv || reset) begin
      checks++;
      if (period !== out.per || high_time !== out.hi) begin
        errors++;
        $display("FAIL measurement @%0d: got period=%0d high=%0d expected period=%0d high=%0d",
                 cyc, period, high_time, out.per, out.hi);
      end
`ifdef TONE_METER_MATCH_EN
      checks++;
      if (locked !== out.lk) begin
        errors++;
        $display("FAIL locked @%0d: got %b expected %b", cyc, locked, out.lk);
      end
`endif
    end
    checks++;
    if (no_tone !== out.nt) begin
      errors++;
      $display("FAIL no_tone @%0d: got %b expected %b", cyc, no_tone, out.nt);
    end

    if (period_valid === 1'b1) begin
      n_pv++;
      last_pv_cyc = cyc;
    end
    if (no_tone === 1'b1 && !nt_prev) nt_rise_cyc = cyc;
    nt_prev = (no_tone === 1'b1);
  endtask

  task automatic tone(input int unsigned h, input int unsigned l, input int unsigned n);
    for (int k = 0; k < int'(n); k++) begin
      repeat (h) step(1'b1);
      repeat (l) step(1'b0);
    end
  endtask

  task automatic do_reset(input bit v);
    reset = 1'b1;
    step(v);
    step(v);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++;
    if (period !== '0 || high_time !== '0 || period_valid !== 1'b0 || no_tone !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got period=%0d high=%0d valid=%b no_tone=%b expected 0 0 0 1",
               period, high_time, period_valid, no_tone);
    end
  endtask

  task automatic test_basic();
    int n0;
    do_reset(1'b0);
    n0 = n_pv;
    tone(40, 40, 4);
    checks++;
    if (n_pv - n0 != 3 || period !== 80 || high_time !== 40 || no_tone !== 1'b0) begin
      errors++;
      $display("FAIL basic_40_40: got pulses=%0d period=%0d high=%0d no_tone=%b expected 3 80 40 0",
               n_pv - n0, period, high_time, no_tone);
    end
  endtask

  task automatic test_timeout();
    int n0;
    tone(40, 40, 2);
    nt_rise_cyc = -1;
    repeat (T + 50) step(1'b0);
    checks++;
    if (nt_rise_cyc < 0 || nt_rise_cyc - last_pv_cyc != int'(T)) begin
      errors++;
      $display("FAIL timeout_delay: got %0d cycles expected %0d", nt_rise_cyc - last_pv_cyc, T);
    end
    n0 = n_pv;
    tone(40, 40, 2);
    checks++;
    if (n_pv - n0 != 1) begin
      errors++;
      $display("FAIL rearm_after_timeout: got %0d pulses expected 1", n_pv - n0);
    end
  endtask

  task automatic test_duty();
    tone(10, 70, 3);
    checks++;
    if (period !== 80 || high_time !== 10) begin
      errors++;
      $display("FAIL duty_10_70: got period=%0d high=%0d expected 80 10", period, high_time);
    end
    tone(1, 1, 6);
    checks++;
    if (period !== 2 || high_time !== 1) begin
      errors++;
      $display("FAIL duty_1_1: got period=%0d high=%0d expected 2 1", period, high_time);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    tone(40, 40, 2);
    repeat (20) step(1'b1);
    reset = 1'b1;
    step(1'b1);
    checks++;
    if (period !== '0 || high_time !== '0 || period_valid !== 1'b0 || no_tone !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got period=%0d high=%0d valid=%b no_tone=%b expected 0 0 0 1",
               period, high_time, period_valid, no_tone);
    end
    reset = 1'b0;
    step(1'b0);
    n0 = n_pv;
    tone(40, 40, 3);
    checks++;
    if (n_pv - n0 != 2 || period !== 80) begin
      errors++;
      $display("FAIL post_reset_measure: got pulses=%0d period=%0d expected 2 80",
               n_pv - n0, period);
    end
  endtask

  task automatic test_boundary();
    do_reset(1'b0);
    tone(100, 100, 3);
    checks++;
    if (period !== T || no_tone !== 1'b0) begin
      errors++;
      $display("FAIL period_eq_timeout: got period=%0d no_tone=%b expected %0d 0", period, no_tone, T);
    end
    tone(100, 101, 3);
    repeat (5) step(1'b0);
    checks++;
    if (no_tone !== 1'b1) begin
      errors++;
      $display("FAIL period_over_timeout: got no_tone=%b expected 1", no_tone);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)));
      tone($urandom_range(1, 60), $urandom_range(1, 170), $urandom_range(1, 3));
    end
  endtask

`ifdef TONE_METER_MATCH_EN
  task automatic test_match();
    int unsigned lens[5];
    lens = '{81, 79, 80, 90, 80};
    m_expv = 80;
    m_tol  = 2;
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      tone(40, lens[k] - 40, 1);
      if (k == 3) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++;
          $display("FAIL match_lock: got locked=%b expected 1", locked);
        end
      end
    end
    checks++;
    if (locked !== 1'b0 || period !== 90) begin
      errors++;
      $display("FAIL match_miss: got locked=%b period=%0d expected 0 90", locked, period);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_timeout();
    test_duty();
    test_reset_mid();
    test_boundary();
`ifdef TONE_METER_MATCH_EN
    test_match();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
